// File: rtl/qsys_pio_pkg.sv
// qsys_pio_pkg: register map and divider width shared by the LED PIO blocks.
package qsys_pio_pkg;
  localparam int DIV_W = 24;
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN  = 3'd1;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd2;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
endpackage

// File: rtl/pio_blink_timer.sv
// pio_blink_timer: divides clk by div and toggles phase at each terminal count.
module pio_blink_timer
  import qsys_pio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             clear,
  output logic             phase
);
  logic [DIV_W-1:0] cnt;
  logic tc;
  assign tc = cnt == div - DIV_W'(1);
  // clear beats terminal count, and a zero divider parks the timer
  always_ff @(posedge clk)
    if (reset || clear || div == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= tc ? '0 : cnt + DIV_W'(1);
      phase <= phase ^ tc;
    end
endmodule

// File: rtl/qsys_led_pio.sv
// qsys_led_pio: Avalon-MM LED/GPIO output port with per-bit hardware blinking.
module qsys_led_pio
  import qsys_pio_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter logic [31:0] DIV_RESET   = 32'd12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] data, blink_en, wd, data_nxt;
  logic [DIV_W-1:0] blink_div;
  logic [31:0] rd_nxt;
  logic wr, div_wr, phase, unused_wd;
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign div_wr    = wr && address == ADDR_BLINK_DIV;
  assign unused_wd = ^writedata;
  assign data_nxt  = !wr                      ? data :
                     address == ADDR_DATA     ? wd :
                     address == ADDR_OUTSET   ? data | wd :
                     address == ADDR_OUTCLEAR ? data & ~wd : data;
  assign rd_nxt    = address == ADDR_DATA      ? 32'(data) :
                     address == ADDR_BLINK_EN  ? 32'(blink_en) :
                     address == ADDR_BLINK_DIV ? 32'(blink_div) : 32'd0;
  pio_blink_timer u_timer (
    .clk  (clk),
    .reset(reset),
    .div  (blink_div),
    .clear(div_wr),
    .phase(phase)
  );
  always_ff @(posedge clk)
    if (reset) begin
      data      <= RESET_VALUE[WIDTH-1:0];
      blink_en  <= '0;
      blink_div <= DIV_RESET[DIV_W-1:0];
      readdata  <= '0;
      out_port  <= RESET_VALUE[WIDTH-1:0];
    end else begin
      data     <= data_nxt;
      if (wr && address == ADDR_BLINK_EN) blink_en <= wd;
      if (div_wr) blink_div <= writedata[DIV_W-1:0];
      readdata <= rd_nxt;
      out_port <= data ^ (blink_en & {WIDTH{phase}});
    end
endmodule

// File: tb/tb_qsys_led_pio.sv
// tb_qsys_led_pio: directed checks of register access, set/clear and blink timing.
module tb_qsys_led_pio;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [15:0] out_port;
  int n_cmp = 0;
  int n_err = 0;

  qsys_led_pio dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // every task starts and ends on a falling edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs = 1'b1);
    address = a; writedata = d; chipselect = cs; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    @(negedge clk);
    chk(tag, readdata, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_rd", readdata, 32'h0);
    reset = 1'b0;
    rd("rd_data0", 3'd0, 32'h0);
    rd("rd_en0", 3'd1, 32'h0);
    rd("rd_div0", 3'd2, 32'h00BEBC20);
    rd("rd_rsv3", 3'd3, 32'h0);

    wr(3'd0, 32'hFFFF_A5A5);
    wr(3'd4, 32'h0000_0F00);
    wr(3'd5, 32'h0000_0005);
    chk("out_lag", 32'(out_port), 32'h0000_AFA5);
    @(negedge clk);
    chk("out_setclr", 32'(out_port), 32'h0000_AFA0);
    rd("rd_setclr", 3'd0, 32'h0000_AFA0);

    wr(3'd0, 32'h0000_1234, 1'b0);
    address = 3'd0; writedata = 32'h0000_5555; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    rd("rd_nocs", 3'd0, 32'h0000_AFA0);
    rd("rd_en_kept", 3'd1, 32'h0);
    rd("rd_div_kept", 3'd2, 32'h00BEBC20);
    rd("rd_set", 3'd4, 32'h0);
    rd("rd_clr", 3'd5, 32'h0);
    rd("rd_rsv6", 3'd6, 32'h0);

    wr(3'd0, 32'h0);
    wr(3'd1, 32'h0000_0001);
    wr(3'd2, 32'd4);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("blink4", 32'(out_port), 32'(((k - 1) / 4) % 2));
    end

    wr(3'd2, 32'd0);
    chk("div0_lag", 32'(out_port), 32'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("div0_hold", 32'(out_port), 32'h0);
    end
    rd("rd_div_zero", 3'd2, 32'h0);

    wr(3'd2, 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("tc_pre", 32'(out_port), 32'h0);
    end
    wr(3'd2, 32'd4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("tc_prio", 32'(out_port), 32'(((k - 1) / 4) % 2));
    end
    repeat (5) @(negedge clk);
    chk("pre_rst_phase", 32'(out_port), 32'h1);

    reset = 1'b1;
    address = 3'd0; writedata = 32'h0000_5555; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;
    chk("mid_rst_out", 32'(out_port), 32'h0);
    chk("mid_rst_rd", readdata, 32'h0);
    rd("rst_wins_data", 3'd0, 32'h0);
    rd("rst_en", 3'd1, 32'h0);
    rd("rst_div", 3'd2, 32'h00BEBC20);

    wr(3'd0, 32'h0000_0F0F);
    wr(3'd1, 32'h0000_8001);
    wr(3'd2, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("blink1", 32'(out_port), ((k - 1) % 2) != 0 ? 32'h0000_8F0E : 32'h0000_0F0F);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
